// File: rtl/cpu_controller.sv
// Instruction sequencer for the 8-bit accumulator CPU: an 8-phase cycle counter
// plus a halt latch, with control strobes decoded combinationally from the current phase.
module cpu_controller #(
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               halt,
  output logic               ld_pc,
  output logic               data_e,
  output logic               ld_ac,
  output logic               wr,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [PHASE_W-1:0] P_INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] P_INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] P_INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] P_IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] P_OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] P_OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] P_ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] P_STORE      = 3'd7;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } strobe_t;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               halted_q, halted_d;
  logic               aluop, is_hlt, is_skz, is_sto, is_jmp;
  strobe_t            st;

  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // HLT parks the counter in OP_ADDR; only reset leaves the halted state.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q && ena) begin
      if (phase_q == P_OP_ADDR && is_hlt) halted_d = 1'b1;
      else                                phase_d  = phase_q + 1'b1;
    end
  end

  always_comb begin
    st = '0;
    if (halted_q) begin
      st.halt = 1'b1;
    end else begin
      case (phase_q)
        P_INST_ADDR:  st.sel = 1'b1;
        P_INST_FETCH: begin st.sel = 1'b1; st.rd = 1'b1; end
        P_INST_LOAD,
        P_IDLE:       begin st.sel = 1'b1; st.rd = 1'b1; st.ld_ir = 1'b1; end
        P_OP_ADDR:    begin st.inc_pc = 1'b1; st.halt = is_hlt; end
        P_OP_FETCH:   st.rd = aluop;
        P_ALU_OP: begin
          st.rd     = aluop;
          st.inc_pc = is_skz && zero;
          st.ld_pc  = is_jmp;
          st.data_e = is_sto;
        end
        P_STORE: begin
          st.rd     = aluop;
          st.ld_ac  = aluop;
          st.inc_pc = is_jmp;
          st.ld_pc  = is_jmp;
          st.wr     = is_sto;
          st.data_e = is_sto;
        end
        default: st = '0;
      endcase
    end
  end

  assign sel    = st.sel;
  assign rd     = st.rd;
  assign ld_ir  = st.ld_ir;
  assign inc_pc = st.inc_pc;
  assign halt   = st.halt;
  assign ld_pc  = st.ld_pc;
  assign data_e = st.data_e;
  assign ld_ac  = st.ld_ac;
  assign wr     = st.wr;
  assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Table-driven bench: one row per clock (inputs + expected phase/strobes for that cycle),
// expectations queued on drive and popped when the settled outputs are sampled.
module tb_cpu_controller;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010,
                         LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  // strobe vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
  localparam logic [8:0] S_NONE = 9'b000000000, S_P0  = 9'b100000000,
                         S_P1   = 9'b110000000, S_P23 = 9'b111000000,
                         S_INC  = 9'b000100000, S_RD  = 9'b010000000,
                         S_HALT = 9'b000010000;

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] exp_phase;
    logic [8:0] exp_st;
  } vec_t;

  typedef struct {
    logic [2:0] phase;
    logic [8:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ena, zero;
  logic [2:0] opcode;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_controller #(.PHASE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
    .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic v(input logic r, input logic e, input logic [2:0] op,
                   input logic z, input logic [2:0] ph, input logic [8:0] s);
    vec_t t;
    t.rst_n = r; t.ena = e; t.opcode = op; t.zero = z;
    t.exp_phase = ph; t.exp_st = s;
    vecs.push_back(t);
  endtask

  // Phases 0..4 look the same for every opcode except HLT.
  task automatic fetch(input logic [2:0] op);
    v(1, 1, op, 0, 3'd0, S_P0);
    v(1, 1, op, 0, 3'd1, S_P1);
    v(1, 1, op, 0, 3'd2, S_P23);
    v(1, 1, op, 0, 3'd3, S_P23);
    v(1, 1, op, 0, 3'd4, S_INC);
  endtask

  initial begin
    exp_t       e;
    logic [8:0] got;

    // ADD: full cycle
    fetch(ADD);
    v(1, 1, ADD, 0, 3'd5, S_RD);
    v(1, 1, ADD, 0, 3'd6, S_RD);
    v(1, 1, ADD, 0, 3'd7, 9'b010000010);
    // STO, zero toggling must not matter
    fetch(STO);
    v(1, 1, STO, 1, 3'd5, S_NONE);
    v(1, 1, STO, 0, 3'd6, 9'b000000100);
    v(1, 1, STO, 1, 3'd7, 9'b000000101);
    // SKZ with zero=1 in phase 6, zero=1 elsewhere has no effect
    fetch(SKZ);
    v(1, 1, SKZ, 1, 3'd5, S_NONE);
    v(1, 1, SKZ, 1, 3'd6, S_INC);
    v(1, 1, SKZ, 1, 3'd7, S_NONE);
    // SKZ with zero=0
    fetch(SKZ);
    v(1, 1, SKZ, 1, 3'd5, S_NONE);
    v(1, 1, SKZ, 0, 3'd6, S_NONE);
    v(1, 1, SKZ, 1, 3'd7, S_NONE);
    // JMP
    fetch(JMP);
    v(1, 1, JMP, 0, 3'd5, S_NONE);
    v(1, 1, JMP, 0, 3'd6, 9'b000001000);
    v(1, 1, JMP, 0, 3'd7, 9'b000101000);
    // LDA with a 3-cycle stall in OP_FETCH
    fetch(LDA);
    v(1, 0, LDA, 0, 3'd5, S_RD);
    v(1, 0, LDA, 0, 3'd5, S_RD);
    v(1, 0, LDA, 0, 3'd5, S_RD);
    v(1, 1, LDA, 0, 3'd5, S_RD);
    v(1, 1, LDA, 0, 3'd6, S_RD);
    v(1, 1, LDA, 0, 3'd7, 9'b010000010);
    // HLT: stalled first, then latch, then frozen while inputs churn
    v(1, 1, HLT, 0, 3'd0, S_P0);
    v(1, 1, HLT, 0, 3'd1, S_P1);
    v(1, 1, HLT, 0, 3'd2, S_P23);
    v(1, 1, HLT, 0, 3'd3, S_P23);
    v(1, 0, HLT, 0, 3'd4, 9'b000110000);
    v(1, 1, HLT, 0, 3'd4, 9'b000110000);
    for (int i = 0; i < 12; i++)
      v(1, logic'(i % 3 != 0), 3'(i), logic'(i[0]), 3'd4, S_HALT);
    v(0, 1, JMP, 1, 3'd4, S_HALT);
    v(1, 1, ADD, 0, 3'd0, S_P0);
    v(1, 1, ADD, 0, 3'd1, S_P1);
    // Reset in STORE of a STO instruction; restarted cycle must be clean
    v(0, 1, ADD, 0, 3'd2, S_P23);
    fetch(STO);
    v(1, 1, STO, 0, 3'd5, S_NONE);
    v(1, 1, STO, 0, 3'd6, 9'b000000100);
    v(0, 1, STO, 0, 3'd7, 9'b000000101);
    v(1, 1, STO, 0, 3'd0, S_P0);
    v(1, 1, STO, 0, 3'd1, S_P1);
    // Wrap 7->0 back-to-back with no gap
    v(1, 1, STO, 0, 3'd2, S_P23);
    v(1, 1, STO, 0, 3'd3, S_P23);
    v(1, 1, STO, 0, 3'd4, S_INC);
    v(1, 1, STO, 0, 3'd5, S_NONE);
    v(1, 1, STO, 0, 3'd6, 9'b000000100);
    v(1, 1, STO, 0, 3'd7, 9'b000000101);
    v(1, 1, ADD, 0, 3'd0, S_P0);

    rst_n = 1'b0; ena = 1'b1; opcode = ADD; zero = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; ena = vecs[i].ena;
      opcode = vecs[i].opcode; zero = vecs[i].zero;
      e.phase = vecs[i].exp_phase; e.st = vecs[i].exp_st;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      got = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
      n_checks++;
      if (phase !== e.phase) begin
        n_fail++;
        $display("FAIL phase row %0d: got %0d expected %0d", i, phase, e.phase);
      end
      n_checks++;
      if (got !== e.st) begin
        n_fail++;
        $display("FAIL strobes row %0d (phase %0d op %0d): got %b expected %b",
                 i, e.phase, vecs[i].opcode, got, e.st);
      end
    end

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction sequencer for the 8-bit accumulator CPU; sits directly upstream of the ALU.
- Steps an 8-phase instruction cycle and decodes the instruction-register opcode into the memory, IR, PC and accumulator control strobes.
- Consumes the ALU zero flag for SKZ.
- Opcode encoding is shared with the ALU: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.

Parameters:
- PHASE_W, 3, phase counter width; fixed at 3 (8 phases), must not be overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  phase-advance enable; 0 stalls the sequencer (e.g. memory wait).
- opcode  input  3  instruction-register opcode, stable from IDLE through STORE.
- zero  input  1  ALU zero flag (accumulator == 0).
- sel  output  1  memory address mux: 1 = PC, 0 = IR operand.
- rd  output  1  memory read strobe.
- ld_ir  output  1  load instruction register.
- inc_pc  output  1  increment program counter.
- halt  output  1  CPU halted.
- ld_pc  output  1  load PC from IR operand.
- data_e  output  1  drive accumulator onto data bus.
- ld_ac  output  1  load accumulator from ALU out.
- wr  output  1  memory write strobe.
- phase  output  3  current phase, for debug and bench.

Behaviour:
- Reset: on a rising clk with rst_n=0, phase<=0 (INST_ADDR) and halted<=0. rst_n overrides ena and the halted state.
- After reset, sel=1 and every other strobe is 0.
- Phases advance 0→1→…→7→0, one step per clk with ena=1 and halted=0. With ena=0, phase holds and outputs stay as decoded for the held phase.
- All strobes are combinational decodes of (phase, opcode, zero, halted); no added latency. ALUOP = ADD|AND|XOR|LDA.
- Phase 0 INST_ADDR: sel=1.
- Phase 1 INST_FETCH: sel=1, rd=1.
- Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
- Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
- Phase 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
- Phase 5 OP_FETCH: rd=ALUOP.
- Phase 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
- Phase 7 STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=JMP; ld_pc=JMP; wr=STO; data_e=STO.
- Any strobe not listed for a phase is 0.
- Halt: a rising clk in phase 4 with opcode==HLT and ena=1 sets halted=1 and leaves phase at 4. inc_pc is 1 only during that first OP_ADDR cycle.
- While halted: halt=1, every other strobe=0, phase frozen at 4. ena, opcode and zero are ignored. Only rst_n=0 exits.
- With ena=0 in phase 4 and opcode=HLT: halt=1 combinationally and halted is not yet set.
- zero is sampled combinationally only in phase 6. Changes in zero during other phases have no effect.
- Reset mid-instruction: the next cycle is phase 0 with sel=1 only, and no stale wr, ld_ac or ld_pc strobe appears.
- The phase counter wraps 7→0 with no idle gap; consecutive instructions take exactly 8 cycles each.

Test Plan:
- Reset/fetch: rst_n=0 for 2 clks, release with ena=1, opcode=ADD → phase 0..7 on consecutive clks. sel=1 in phases 0-3. rd=1 in phases 1,2,3,5,6,7. ld_ir=1 in phases 2-3. inc_pc=1 in phase 4. ld_ac=1 in phase 7 only.
- STO: opcode=STO → rd=0 in phases 5-7; data_e=1 in phases 6-7; wr=1 only in phase 7; ld_ac=0 throughout.
- SKZ and JMP: opcode=SKZ, zero=1 → inc_pc=1 in phase 6. zero=0 → inc_pc=0 in phase 6. opcode=JMP → ld_pc=1 in phases 6-7 and inc_pc=1 in phase 7.
- Stall: ena=0 for 3 clks while in phase 5 with opcode=LDA → phase stays 5 and rd=1 held. ena=1 → phase 6 on the next clk.
- Halt: opcode=HLT reaches phase 4 → halt=1 and inc_pc=1 for one cycle, then halt=1 with all else 0 for 10+ clks while opcode toggles. rst_n=0 for 1 clk → phase=0, halt=0.
- Mid-op reset: assert rst_n=0 in phase 7 with opcode=STO → next cycle phase=0, wr=0, data_e=0.
